instr_fetch_unit: RTL

- Produces the instruction stream that the decode/control stage consumes.
- Owns the program counter and issues word reads to instruction memory over a req/gnt/rvalid interface.
- Buffers returned words with their PC in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts a branch/jump redirect from the execute side, which flushes all buffered and in-flight fetches.

---
 rtl/instr_fetch_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues single-outstanding word reads to
// instruction memory, and buffers returned words with their PC for decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i,
  input  logic        br_sel_i,
  input  logic [31:0] br_target_i
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [2:0]  DEPTH    = 3'(BUF_DEPTH);
  localparam logic [1:0]  PTR_LAST = 2'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_FLUSH} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic        outstanding;
  logic [31:0] last_pc;
  logic [31:0] buf_data [4];
  logic [31:0] buf_pc   [4];
  logic [1:0]  head;
  logic [1:0]  tail;
  logic [2:0]  count;

  logic req;
  logic handshake;
  logic has_data;
  logic push;
  logic pop;
  logic resp_pending;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    req          = (state == S_FETCH) && ((count + {2'b00, outstanding}) < DEPTH) && !br_sel_i;
    handshake    = req && imem_gnt_i;
    has_data     = (count != 3'd0);
    push         = (state == S_WAIT) && imem_rvalid_i && !br_sel_i;
    pop          = has_data && !br_sel_i && instr_ready_i;
    resp_pending = outstanding && !imem_rvalid_i;
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = fetch_pc;
  assign instr_valid_o = has_data && !br_sel_i;
  assign instr_o       = has_data ? buf_data[head] : NOP;
  assign pc_o          = has_data ? buf_pc[head] : last_pc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      last_pc     <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      if (has_data) last_pc <= buf_pc[head];

      if (br_sel_i) begin
        // A response arriving in the redirect cycle is consumed here, so FLUSH
        // is only needed while the old response is still in flight.
        fetch_pc    <= {br_target_i[31:2], 2'b00};
        head        <= '0;
        tail        <= '0;
        count       <= '0;
        outstanding <= resp_pending;
        state       <= resp_pending ? S_FLUSH : S_FETCH;
      end else begin
        case (state)
          S_IDLE:  state <= S_FETCH;
          S_FETCH: if (handshake) begin
            outstanding <= 1'b1;
            req_pc      <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
            state       <= S_WAIT;
          end
          S_WAIT, S_FLUSH: if (imem_rvalid_i) begin
            outstanding <= 1'b0;
            state       <= S_FETCH;
          end
          default: state <= S_IDLE;
        endcase

        if (push) begin
          buf_data[tail] <= imem_rdata_i;
          buf_pc[tail]   <= req_pc;
          tail           <= ptr_next(tail);
        end
        if (pop) head <= ptr_next(head);
        case ({push, pop})
          2'b10:   count <= count + 3'd1;
          2'b01:   count <= count - 3'd1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      no_push_when_full: assert (!(push && !pop && count == DEPTH));
    end
  end

endmodule
